fb_scanout: RTL and testbench
=============================

# fb_scanout

Video scanout engine that consumes the framebuffer output data stream and drives display timing. It requests one pixel per fetch slot through the stream interface, and replicates pixels horizontally and lines vertically by an integer `SCALE` using an internal line buffer. It produces hsync/vsync/data-enable and 4-bit RGB for the video encoder. It sits in the `clk_pix` domain, between the framebuffer's stream port and the video output.

## Interface
Parameters:
- `FB_WIDTH`, 128: framebuffer width in pixels; must be a multiple of 8.
- `FB_HEIGHT`, 128: framebuffer height in lines.
- `SCALE`, 2: integer replication factor, 1–4. Requires `FB_WIDTH*SCALE <= H_ACTIVE` and `FB_HEIGHT*SCALE <= V_ACTIVE`.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.

Ports:
- `clk_pix`  in  1  pixel clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `base_address_i`  in  24  framebuffer base address.
- `stream_start_frame_o`  out  1  one-cycle frame-start pulse.
- `stream_base_address_o`  out  24  base address latched at the frame-start pulse.
- `stream_ena_o`  out  1  request the next stream word.
- `stream_data_i`  in  16  stream pixel, ARGB4444: A[15:12], R[11:8], G[7:4], B[3:0].
- `stream_err_underflow_i`  in  1  underflow pulse from the framebuffer.
- `hsync_o`, `vsync_o`  out  1  active-low syncs.
- `de_o`  out  1  active video.
- `red_o`, `green_o`, `blue_o`  out  4  pixel colour.
- `underflow_o`  out  1  sticky underflow flag.

## Operation
- Counters: `hcnt` runs 0..799 and `vcnt` runs 0..524 with the default timing; `hcnt` wraps at line end and `vcnt` increments on that wrap.
- Active area: `hcnt<H_ACTIVE && vcnt<V_ACTIVE`. The FB region is `hcnt<FB_WIDTH*SCALE && vcnt<FB_HEIGHT*SCALE`, anchored top-left.
- Sub-counters: `sx` and `sy` run 0..SCALE-1 inside the FB region. `fx` = FB column, `fy` = FB row.
- Fetch slot: inside the FB region with `sy==0 && sx==0`. This gives exactly FB_WIDTH*FB_HEIGHT fetches per frame, a multiple of 8, which keeps the framebuffer's 8-word burst alignment.
- Line buffer (FB_WIDTH×16):
  - On `sy==0`, stream data is written at `fx`.
  - On `sy>0`, the pixel is read from `fx`. No stream fetch occurs on these lines.
- Pixel hold: the output pixel register loads at `sx==0` and holds for SCALE cycles.
- Colour:
  - Inside the FB region, RGB is the A-independent R/G/B nibbles.
  - Active area outside the FB region is black.
  - Blanking is black with `de_o=0`.
- Frame start: when counters reach (`hcnt`=0, `vcnt`=V_ACTIVE), pulse `stream_start_frame_o` and latch `base_address_i` into `stream_base_address_o`. Changes to `base_address_i` at any other time are ignored.
- Underflow: `stream_err_underflow_i` sets `underflow_o`. Only reset clears it. Output continues with whatever data arrives.
- Syncs: hsync is low for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is defined the same way on `vcnt`.

## Timing
- Pipeline has three stages: S0 counters, S1 registered `stream_ena_o` and line-buffer read address, S2 registered video outputs.
- `stream_ena_o` is high one cycle after the counters sit on a fetch slot. `stream_data_i` is valid the cycle after `stream_ena_o` and is sampled into S2.
- `hsync_o`/`vsync_o`/`de_o`/RGB lag the counters by exactly 2 cycles. Syncs are delayed identically so pixel and sync stay aligned.
- Line-buffer read has 1-cycle latency (S1 address, S2 data). Writes occur in S2.
- `stream_start_frame_o` is registered: high for exactly one cycle per frame, and `stream_base_address_o` updates in the same cycle.
- Reset values: `hsync_o`=1, `vsync_o`=1, `de_o`=0, RGB=0, `stream_ena_o`=0, `stream_start_frame_o`=0, `stream_base_address_o`=`base_address_i` sampled during reset, `underflow_o`=0, counters (0,0), pipeline valid bits cleared.
- Reset mid-frame: all of the above applies on the next edge. Counting restarts at (0,0) after `reset_i` falls. No stale `stream_ena_o` pulse may emerge from the pipeline.
- `SCALE==1`: every FB-region pixel is a fetch slot, and the line buffer is written but never read.

## Structure
- Shared package `video_pkg`:
  - default 640×480 timing constants;
  - ARGB4444 field slice localparams;
  - `vid_out_t` struct {hsync, vsync, de, r, g, b}.
- Sub-module `line_buffer`: simple dual-port synchronous RAM, parameters DEPTH and WIDTH, one write port and one registered read port.

## Test plan
- Reset: hold `reset_i` for 4 cycles → `hsync_o`=1, `vsync_o`=1, `de_o`=0, RGB=0, `stream_ena_o`=0, `underflow_o`=0; the first `de_o` rises 2 cycles after release.
- Frame timing: run 2 frames → period 420000 cycles; hsync low for 96 cycles starting 658 cycles after line start; vsync low for 2 lines; `de_o` high for 640×480 cycles per frame.
- Default config (128/128/SCALE=2), `stream_data_i`=16'h0F00 → 16384 `stream_ena_o` pulses per frame on even lines, spaced 2 cycles apart; red_o=F, green=0, blue=0 on pixels 0–255 of lines 0–255; odd lines have no fetch and show the same colours from the line buffer.
- Border: at `hcnt` 256..639 and lines 256..479 → `de_o`=1, RGB=0, `stream_ena_o`=0.
- Frame start: `base_address_i`=24'h010000, changed to 24'h020000 at line 100 → exactly one `stream_start_frame_o` per frame at line 480 (+1 cycle); `stream_base_address_o` reads 24'h010000 until the pulse after the change.
- Underflow and reset: a one-cycle `stream_err_underflow_i` → `underflow_o`=1 until reset; `reset_i` asserted at line 50 → outputs return to reset values next cycle and counting restarts at (0,0).

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: default 640x480 timing, ARGB4444 field positions
// and the registered video output bundle.
package video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned NIB_W  = 4;

    localparam int unsigned ARGB_A_LSB = 12;
    localparam int unsigned ARGB_R_LSB = 8;
    localparam int unsigned ARGB_G_LSB = 4;
    localparam int unsigned ARGB_B_LSB = 0;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             de;
        logic [NIB_W-1:0] r;
        logic [NIB_W-1:0] g;
        logic [NIB_W-1:0] b;
    } vid_out_t;

    localparam vid_out_t VID_BLANK = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0,
                                       r: '0, g: '0, b: '0};

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer stream port: the scanout engine (master) requests words,
// the framebuffer (slave) supplies them.
interface fb_scanout_if;
    import video_pkg::*;

    logic              start_frame;
    logic [ADDR_W-1:0] base_address;
    logic              ena;
    logic [PIX_W-1:0]  data;
    logic              err_underflow;

    modport master (
        output start_frame,
        output base_address,
        output ena,
        input  data,
        input  err_underflow
    );

    modport slave (
        input  start_frame,
        input  base_address,
        input  ena,
        output data,
        output err_underflow
    );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module line_buffer #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_pix,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_pix) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Video scanout: display timing, one stream fetch per framebuffer pixel,
// SCALE-fold pixel/line replication through a one-line buffer.
module fb_scanout
    import video_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 128,
    parameter int unsigned FB_HEIGHT = 128,
    parameter int unsigned SCALE     = 2,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input  logic              clk_pix,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] base_address_i,
    fb_scanout_if.master      stream,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [NIB_W-1:0]  red_o,
    output logic [NIB_W-1:0]  green_o,
    output logic [NIB_W-1:0]  blue_o,
    output logic              underflow_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned FXW     = $clog2(FB_WIDTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_FB_END = HW'(FB_WIDTH * SCALE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_FB_END = VW'(FB_HEIGHT * SCALE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);

    // ---------------- S0: raster counters ----------------
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic [SW-1:0]  sx;
    logic [SW-1:0]  sy;
    logic [FXW-1:0] fx;

    logic h_last, v_last, in_fb_h, in_fb_v, in_fb;
    logic fetch_slot, lb_rd_en, active, hs_n, vs_n, frame_point;

    always_comb begin
        h_last      = (hcnt == H_LAST);
        v_last      = (vcnt == V_LAST);
        in_fb_h     = (hcnt < H_FB_END);
        in_fb_v     = (vcnt < V_FB_END);
        in_fb       = in_fb_h && in_fb_v;
        fetch_slot  = in_fb && (sx == '0) && (sy == '0);
        lb_rd_en    = in_fb && (sx == '0) && (sy != '0);
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_n        = !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
        vs_n        = !((vcnt >= VS_BEGIN) && (vcnt < VS_END));
        frame_point = (hcnt == '0) && (vcnt == V_ACT);
    end

    // sx/fx follow hcnt inside the FB columns; sy follows vcnt inside the FB rows
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            hcnt <= '0;
            vcnt <= '0;
            sx   <= '0;
            sy   <= '0;
            fx   <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            sx   <= '0;
            fx   <= '0;
            if (v_last) begin
                vcnt <= '0;
                sy   <= '0;
            end else begin
                vcnt <= vcnt + VW'(1);
                if (in_fb_v) begin
                    sy <= (sy == S_LAST) ? '0 : sy + SW'(1);
                end
            end
        end else begin
            hcnt <= hcnt + HW'(1);
            if (in_fb_h) begin
                if (sx == S_LAST) begin
                    sx <= '0;
                    fx <= fx + FXW'(1);
                end else begin
                    sx <= sx + SW'(1);
                end
            end
        end
    end

    // ---------------- S1: fetch request and pixel context ----------------
    logic           s1_valid, s1_in_fb, s1_active, s1_hs_n, s1_vs_n, s1_sx0, s1_sy0;
    logic [FXW-1:0] s1_fx;

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            s1_valid   <= 1'b0;
            stream.ena <= 1'b0;
            s1_in_fb   <= 1'b0;
            s1_active  <= 1'b0;
            s1_hs_n    <= 1'b1;
            s1_vs_n    <= 1'b1;
            s1_sx0     <= 1'b0;
            s1_sy0     <= 1'b0;
            s1_fx      <= '0;
        end else begin
            s1_valid   <= 1'b1;
            stream.ena <= fetch_slot;
            s1_in_fb   <= in_fb;
            s1_active  <= active;
            s1_hs_n    <= hs_n;
            s1_vs_n    <= vs_n;
            s1_sx0     <= (sx == '0);
            s1_sy0     <= (sy == '0);
            s1_fx      <= fx;
        end
    end

    // Read is issued from the S0 column so the stored word is ready alongside S1.
    logic [PIX_W-1:0] lb_rd_data;

    line_buffer #(
        .DEPTH (FB_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buffer (
        .clk_pix (clk_pix),
        .wr_en   (stream.ena),
        .wr_addr (s1_fx),
        .wr_data (stream.data),
        .rd_en   (lb_rd_en),
        .rd_addr (fx),
        .rd_data (lb_rd_data)
    );

    // ---------------- S2: registered video ----------------
    vid_out_t         vid_q, vid_d;
    logic [PIX_W-1:0] src;
    logic             unused_alpha;

    assign src          = s1_sy0 ? stream.data : lb_rd_data;
    assign unused_alpha = ^src[ARGB_A_LSB +: NIB_W];

    // Within the FB region a non-zero sx means the previous output was the same
    // FB pixel, so the output register itself serves as the hold register.
    always_comb begin
        vid_d = VID_BLANK;
        if (s1_valid) begin
            vid_d.hsync = s1_hs_n;
            vid_d.vsync = s1_vs_n;
            vid_d.de    = s1_active;
            if (s1_in_fb) begin
                if (s1_sx0) begin
                    vid_d.r = src[ARGB_R_LSB +: NIB_W];
                    vid_d.g = src[ARGB_G_LSB +: NIB_W];
                    vid_d.b = src[ARGB_B_LSB +: NIB_W];
                end else begin
                    vid_d.r = vid_q.r;
                    vid_d.g = vid_q.g;
                    vid_d.b = vid_q.b;
                end
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            vid_q <= VID_BLANK;
        end else begin
            vid_q <= vid_d;
        end
    end

    assign hsync_o = vid_q.hsync;
    assign vsync_o = vid_q.vsync;
    assign de_o    = vid_q.de;
    assign red_o   = vid_q.r;
    assign green_o = vid_q.g;
    assign blue_o  = vid_q.b;

    // ---------------- frame start, base address, underflow ----------------
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            stream.start_frame  <= 1'b0;
            stream.base_address <= base_address_i;
            underflow_o         <= 1'b0;
        end else begin
            stream.start_frame <= frame_point;
            if (frame_point) begin
                stream.base_address <= base_address_i;
            end
            if (stream.err_underflow) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster, checked every cycle against a
// position-based model of the display, plus literal frame-level totals.
module tb_fb_scanout;

    localparam int FBW = 16;
    localparam int FBH = 8;
    localparam int S   = 2;
    localparam int HA  = 40;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int VA  = 20;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic        clk_pix = 1'b0;
    logic        reset_i;
    logic [23:0] base_address_i;
    logic        hsync_o, vsync_o, de_o, underflow_o;
    logic [3:0]  red_o, green_o, blue_o;

    fb_scanout_if sif ();

    fb_scanout #(
        .FB_WIDTH  (FBW),
        .FB_HEIGHT (FBH),
        .SCALE     (S),
        .H_ACTIVE  (HA),
        .H_FP      (HFP),
        .H_SYNC    (HS),
        .H_BP      (HBP),
        .V_ACTIVE  (VA),
        .V_FP      (VFP),
        .V_SYNC    (VS),
        .V_BP      (VBP)
    ) dut (
        .clk_pix        (clk_pix),
        .reset_i        (reset_i),
        .base_address_i (base_address_i),
        .stream         (sif),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .de_o           (de_o),
        .red_o          (red_o),
        .green_o        (green_o),
        .blue_o         (blue_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_fetch(input int p);
        int h;
        int v;
        h = p % HT;
        v = p / HT;
        return (h < FBW * S) && (v < FBH * S) && (h % S == 0) && (v % S == 0);
    endfunction

    // n = clock edges since reset released; counters sit on raster position n mod FT
    int          n = 0;
    bit          model_on = 1'b0;
    logic [23:0] exp_base;
    logic        exp_uf;
    logic [15:0] pix [FBW * FBH];

    always @(posedge clk_pix) begin
        if (reset_i) begin
            n        <= 0;
            exp_base <= base_address_i;
            exp_uf   <= 1'b0;
        end else begin
            n <= n + 1;
            if (n % FT == VA * HT) exp_base <= base_address_i;
            if (sif.err_underflow) exp_uf <= 1'b1;
        end
    end

    always @(negedge clk_pix) begin : compare
        int p;
        int h;
        int v;
        logic [15:0] ep;
        logic [11:0] ergb;
        logic ehs, evs, ede, eena, esf;
        if (model_on) begin
            ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = '0; eena = 1'b0; esf = 1'b0;
            p = 0;
            if (n >= 2) begin
                p = (n - 2) % FT;
                h = p % HT;
                v = p / HT;
                ede = (h < HA) && (v < VA);
                ehs = !((h >= HA + HFP) && (h < HA + HFP + HS));
                evs = !((v >= VA + VFP) && (v < VA + VFP + VS));
                if (h < FBW * S && v < FBH * S) begin
                    ep   = pix[(v / S) * FBW + h / S];
                    ergb = ep[11:0];
                end
            end
            if (n >= 1) begin
                p    = (n - 1) % FT;
                eena = is_fetch(p);
                esf  = (p == VA * HT);
            end
            check("hsync", 32'(hsync_o), 32'(ehs));
            check("vsync", 32'(vsync_o), 32'(evs));
            check("de", 32'(de_o), 32'(ede));
            check("rgb", 32'({red_o, green_o, blue_o}), 32'(ergb));
            check("stream_ena", 32'(sif.ena), 32'(eena));
            check("start_frame", 32'(sif.start_frame), 32'(esf));
            check("base_address", 32'(sif.base_address), 32'(exp_base));
            check("underflow", 32'(underflow_o), 32'(exp_uf));
            if (eena) begin
                h = p % HT;
                v = p / HT;
                pix[(v / S) * FBW + h / S] = sif.data;
            end
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic drive_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            sif.data = 16'($urandom);
            if ($urandom_range(0, 299) == 0) base_address_i = 24'($urandom);
            tick();
        end
    endtask

    task automatic wait_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FT && !seen; i++) begin
            tick();
            if (sif.start_frame) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin : stim
        int lat;
        int cnt;
        int ena_c, de_c, hs_c, vs_c, red_c, other_c, sf_c, sf_at;
        bit found;

        reset_i           = 1'b1;
        base_address_i    = 24'h010000;
        sif.data          = 16'h0F00;
        sif.err_underflow = 1'b0;
        for (int i = 0; i < FBW * FBH; i++) pix[i] = '0;
        tick();
        model_on = 1'b1;
        repeat (3) tick();

        check("rst_hsync", 32'(hsync_o), 32'd1);
        check("rst_vsync", 32'(vsync_o), 32'd1);
        check("rst_de", 32'(de_o), 32'd0);
        check("rst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
        check("rst_ena", 32'(sif.ena), 32'd0);
        check("rst_underflow", 32'(underflow_o), 32'd0);
        check("rst_base", 32'(sif.base_address), 32'h010000);

        reset_i = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            tick();
            if (de_o) begin
                lat   = i;
                found = 1'b1;
            end
        end
        check("first_de_latency", 32'(lat), 32'd2);

        // one full frame of constant red between consecutive start pulses
        wait_start("start_timeout_a");
        ena_c = 0; de_c = 0; hs_c = 0; vs_c = 0; red_c = 0; other_c = 0; sf_c = 0; sf_at = 0;
        for (int i = 1; i <= FT; i++) begin
            tick();
            if (sif.ena) ena_c++;
            if (de_o) de_c++;
            if (!hsync_o) hs_c++;
            if (!vsync_o) vs_c++;
            if (red_o == 4'hF) red_c++;
            if (green_o != 4'h0 || blue_o != 4'h0) other_c++;
            if (sif.start_frame) begin
                sf_c++;
                sf_at = i;
            end
        end
        check("frame_period", 32'(sf_at), 32'd1512);
        check("starts_per_frame", 32'(sf_c), 32'd1);
        check("fetches_per_frame", 32'(ena_c), 32'd128);
        check("de_per_frame", 32'(de_c), 32'd800);
        check("hsync_low_per_frame", 32'(hs_c), 32'd162);
        check("vsync_low_per_frame", 32'(vs_c), 32'd112);
        check("red_pixels", 32'(red_c), 32'd512);
        check("green_blue_pixels", 32'(other_c), 32'd0);

        repeat (3 * HT) tick();
        base_address_i = 24'h020000;
        tick();
        check("base_held", 32'(sif.base_address), 32'h010000);
        wait_start("start_timeout_b");
        check("base_updated", 32'(sif.base_address), 32'h020000);

        drive_random(3 * FT);

        sif.err_underflow = 1'b1;
        tick();
        sif.err_underflow = 1'b0;
        check("underflow_set", 32'(underflow_o), 32'd1);
        drive_random(4 * HT);
        check("underflow_sticky", 32'(underflow_o), 32'd1);

        // reset in the middle of FB line 5
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            if (n % FT == 5 * HT + 17) found = 1'b1;
            else drive_random(1);
        end
        check("reset_point_reached", 32'(found), 32'd1);
        reset_i = 1'b1;
        tick();
        check("mid_rst_hsync", 32'(hsync_o), 32'd1);
        check("mid_rst_vsync", 32'(vsync_o), 32'd1);
        check("mid_rst_de", 32'(de_o), 32'd0);
        check("mid_rst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
        check("mid_rst_ena", 32'(sif.ena), 32'd0);
        check("mid_rst_start", 32'(sif.start_frame), 32'd0);
        check("mid_rst_underflow", 32'(underflow_o), 32'd0);
        check("mid_rst_base", 32'(sif.base_address), 32'(base_address_i));
        tick();
        reset_i = 1'b0;

        found = 1'b0;
        cnt   = 0;
        for (int i = 1; i <= 2 * FT && !found; i++) begin
            sif.data = 16'($urandom);
            tick();
            if (sif.start_frame) begin
                found = 1'b1;
                cnt   = i;
            end
        end
        check("restart_first_start", 32'(cnt), 32'd1121);

        drive_random(2 * FT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
